// File: rtl/phy_pkg.sv
// Shared PHY lane definitions: alignment symbol, lane-word format and rx FSM states.
// Imported by both the transmit and receive sides so the two stay in agreement.
package phy_pkg;

    localparam logic [7:0] COM_SYM = 8'hBC;
    localparam int         LANE_W  = 9;

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        LOCKED
    } rx_state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } lane_word_t;

endpackage

// File: rtl/phy_rx_com_detector.sv
// Serial-in shift register (MSB of each byte first) plus COM symbol comparator.
// sr_o[7] holds the oldest bit; com_match_o is combinational on the registered window.
module phy_rx_com_detector
    import phy_pkg::*;
#(
    parameter logic [7:0] COM = COM_SYM
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       serial_i,
    output logic [7:0] sr_o,
    output logic       com_match_o
);

    logic [7:0] sr_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[6:0], serial_i};
        end
    end

    assign sr_o        = sr_q;
    assign com_match_o = (sr_q == COM);

endmodule

// File: rtl/phy_rx_serial_paralelo.sv
// Single-lane receive deserializer: acquires byte alignment from repeated COM symbols,
// then emits one {valid, data} lane word every 8 bit-clocks while locked.
module phy_rx_serial_paralelo
    import phy_pkg::*;
#(
    parameter int unsigned BC_LOCK = 4,
    parameter logic [7:0]  COM     = COM_SYM
) (
    input  logic              clk16f,
    input  logic              reset,
    input  logic              serial_in,
    output logic [LANE_W-1:0] paralelo_out,
    output logic              byte_stb,
    output logic              active
);

    localparam logic [3:0] BC_LOCK_W = 4'(BC_LOCK);

    logic [7:0] sr;
    logic       com_match;
    logic       boundary;

    rx_state_t  state_q, state_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    lane_word_t out_q, out_d;
    logic       stb_q, stb_d;

    phy_rx_com_detector #(
        .COM (COM)
    ) u_com_detector (
        .clk_i       (clk16f),
        .rst_i       (reset),
        .serial_i    (serial_in),
        .sr_o        (sr),
        .com_match_o (com_match)
    );

    // bit_cnt_q == 0 marks every 8th cycle after the COM that fixed the alignment.
    assign boundary = (bit_cnt_q == 3'd0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        out_d     = out_q;
        stb_d     = 1'b0;

        unique case (state_q)
            SEARCH: begin
                if (com_match) begin
                    bit_cnt_d = 3'd1;
                    com_cnt_d = 4'd1;
                    state_d   = (BC_LOCK == 1) ? LOCKED : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (com_match) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_d == BC_LOCK_W) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        com_cnt_d = 4'd0;
                        state_d   = SEARCH;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    stb_d = 1'b1;
                    if (com_match) begin
                        out_d = '0;
                    end else begin
                        out_d.valid = 1'b1;
                        out_d.data  = sr;
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk16f or posedge reset) begin
        if (reset) begin
            state_q   <= SEARCH;
            com_cnt_q <= '0;
            bit_cnt_q <= '0;
            out_q     <= '0;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            com_cnt_q <= com_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            out_q     <= out_d;
            stb_q     <= stb_d;
        end
    end

    assign paralelo_out = out_q;
    assign byte_stb     = stb_q;
    assign active       = (state_q == LOCKED);

endmodule

// File: doc/phy_rx_serial_paralelo.md
# phy_rx_serial_paralelo

Single-lane receive deserializer for the PHY link. It takes the 1-bit serial stream produced by the PHY transmitter's parallel-to-serial stage and finds byte alignment from the COM idle symbol (8'hBC). It then delivers each received byte as a 9-bit lane word {valid, data[7:0]}, the same lane format used on the transmit-side parallel inputs. It sits at the front of the PHY receive path, ahead of the lane demux and byte-to-word conversion.

## Interface
Parameters:
- BC_LOCK, default 4: number of consecutive COM symbols, on the same byte alignment, required before lock is declared (legal 1–15).
- COM, default 8'hBC: idle/alignment symbol.

Ports:
- clk16f  input  1  bit clock; one serial bit is sampled per rising edge. This is the only clock.
- reset  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial data, MSB of each byte first.
- paralelo_out  output  9  {valid, data[7:0]}, registered.
- byte_stb  output  1  one-cycle pulse; paralelo_out was updated this cycle.
- active  output  1  high while in LOCKED.

## Operation
- Shift register: sr <= {sr[6:0], serial_in} on every edge. sr[7] is the oldest bit.
- FSM states: SEARCH, ALIGN, LOCKED.
- SEARCH
  - sr is compared against COM every cycle.
  - On a match: go to ALIGN, set com_cnt = 1, and restart the bit counter. The match cycle defines byte alignment.
  - If BC_LOCK == 1, go directly to LOCKED.
- Boundary checks: after alignment is set, a check happens exactly every 8 cycles following the detection cycle (t+8, t+16, …).
- ALIGN, at each boundary check:
  - sr == COM: com_cnt++. When com_cnt reaches BC_LOCK, go to LOCKED.
  - Any other byte: return to SEARCH and clear com_cnt. Between checks, sr is not compared.
- LOCKED, at each boundary check, byte_stb pulses and paralelo_out loads:
  - sr == COM: 9'h000 (idle, invalid).
  - Any other byte: {1'b1, sr}.
- LOCKED is left only by reset. No loss-of-lock detection in this block.
- Outside LOCKED: byte_stb = 0, and paralelo_out holds its last value (9'h000 after reset).

## Timing
- Reset values (applied asynchronously and immediately):
  - paralelo_out = 9'h000, byte_stb = 0, active = 0.
  - FSM = SEARCH, sr = 0, com_cnt = 0, bit counter = 0.
- Reset asserted mid-byte or mid-lock aborts everything; no partial byte is emitted. Reacquisition starts from SEARCH on the first edge after deassertion.
- Detection latency: a COM whose last bit is sampled at edge n is seen in sr during cycle n+1. That is the detection cycle t.
- Lock latency with BC_LOCK = 4: active rises on the edge that closes the 3rd boundary check (t+24). It is high from cycle t+25.
- Data latency: the last bit of a byte sampled at edge n produces paralelo_out and byte_stb valid during cycle n+2 (one register stage after sr).
- byte_stb rate in LOCKED: exactly one pulse every 8 cycles, never back-to-back.
- Bit counter wraps 7→0 with no gap. It continues counting across idle COMs.
- Simultaneous events:
  - A COM that completes in the same cycle as the transition to LOCKED is consumed as a lock symbol. It is not emitted.
  - The first emitted byte is the one at the next boundary.
- A COM pattern straddling a byte boundary while in ALIGN or LOCKED is ignored. It does not realign.

## Structure
- Shared package phy_pkg holds:
  - COM_SYM = 8'hBC
  - LANE_W = 9
  - the rx FSM state typedef {SEARCH, ALIGN, LOCKED}
  - the 9-bit lane-word typedef
- The transmit side imports the same COM_SYM and LANE_W.
- One natural sub-module: phy_rx_com_detector. It contains the 8-bit shift register plus the COM comparator, and outputs sr and com_match. The FSM, counters and output registers stay in the top.

## Test plan
- Reset check: hold reset high and toggle serial_in randomly → paralelo_out = 9'h000, byte_stb = 0, active = 0 throughout. Assert reset again mid-lock → all outputs clear within the same cycle.
- Basic lock: send 4×BC then FF, F5, FA, F4 (MSB first) → active rises at detection+25. Then paralelo_out = 1FF, 1F5, 1FA, 1F4 on successive byte_stb pulses spaced 8 cycles apart.
- Misaligned start: send 3 random bits, then 4×BC, then 55 → lock is achieved on the shifted alignment and the first emitted word is 9'h155.
- False start: send BC, then 7F, then 4×BC, then FF → first ALIGN aborts (active stays 0). A later lock then emits 9'h1FF.
- Idle in lock: after lock, send FF, BC, 55 → paralelo_out = 1FF, 000, 155, each with a strobe.
- Parameter sweep: BC_LOCK = 1 → a single BC gives active at detection+1, and the following byte 0xAA gives 9'h1AA.
